// File: rtl/eth_axis_hdr_rx_pkg.sv
// Shared types and constants for the byte-wide Ethernet header parser.
package eth_axis_hdr_rx_pkg;

  localparam int ETH_HDR_LEN = 14;
  localparam int MAC_W       = 48;
  localparam int TYPE_W      = 16;
  localparam int HDR_W       = ETH_HDR_LEN * 8;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_DROP
  } state_t;

  // Field order matches wire order: the first received byte lands in the MSBs.
  typedef struct packed {
    logic [MAC_W-1:0]  dest;
    logic [MAC_W-1:0]  src;
    logic [TYPE_W-1:0] etype;
  } eth_hdr_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } axis_beat_t;

endpackage

// File: rtl/eth_axis_hdr_rx_if.sv
// Stream and header handshake bundle for eth_axis_hdr_rx; slave is the parser view.
interface eth_axis_hdr_rx_if;
  import eth_axis_hdr_rx_pkg::*;

  logic [7:0]        s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              s_axis_tlast;
  logic              s_axis_tuser;
  logic              m_eth_hdr_valid;
  logic              m_eth_hdr_ready;
  logic [MAC_W-1:0]  m_eth_dest_mac;
  logic [MAC_W-1:0]  m_eth_src_mac;
  logic [TYPE_W-1:0] m_eth_type;
  logic [7:0]        m_eth_payload_axis_tdata;
  logic              m_eth_payload_axis_tvalid;
  logic              m_eth_payload_axis_tready;
  logic              m_eth_payload_axis_tlast;
  logic              m_eth_payload_axis_tuser;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
           m_eth_hdr_ready, m_eth_payload_axis_tready,
    output s_axis_tready, m_eth_hdr_valid, m_eth_dest_mac, m_eth_src_mac,
           m_eth_type, m_eth_payload_axis_tdata, m_eth_payload_axis_tvalid,
           m_eth_payload_axis_tlast, m_eth_payload_axis_tuser
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
           m_eth_hdr_ready, m_eth_payload_axis_tready,
    input  s_axis_tready, m_eth_hdr_valid, m_eth_dest_mac, m_eth_src_mac,
           m_eth_type, m_eth_payload_axis_tdata, m_eth_payload_axis_tvalid,
           m_eth_payload_axis_tlast, m_eth_payload_axis_tuser
  );

endinterface

// File: rtl/eth_axis_hdr_rx_skid.sv
// Two-entry payload skid buffer (output register + temp register) with registered ready.
module axis_skid_buf_8
  import eth_axis_hdr_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data_i,
  input  logic       s_last_i,
  input  logic       s_user_i,
  input  logic       s_valid_i,
  output logic       s_ready_o,
  output logic [7:0] m_data_o,
  output logic       m_last_o,
  output logic       m_user_o,
  output logic       m_valid_o,
  input  logic       m_ready_i
);

  axis_beat_t out_q, out_d, tmp_q, tmp_d, in_beat;
  logic       out_valid_q, out_valid_d, tmp_valid_q, tmp_valid_d;
  logic       ready_q, in_xfer;

  assign in_beat = '{data: s_data_i, last: s_last_i, user: s_user_i};
  assign in_xfer = s_valid_i && ready_q;

  // Ready is only ever high while temp is empty, so temp never overflows.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    tmp_d       = tmp_q;
    tmp_valid_d = tmp_valid_q;
    if (!out_valid_q || m_ready_i) begin
      if (tmp_valid_q) begin
        out_d       = tmp_q;
        out_valid_d = 1'b1;
        tmp_valid_d = 1'b0;
      end else begin
        out_valid_d = in_xfer;
        if (in_xfer) out_d = in_beat;
      end
    end else if (in_xfer) begin
      tmp_d       = in_beat;
      tmp_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      tmp_q       <= '0;
      out_valid_q <= 1'b0;
      tmp_valid_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      out_q       <= out_d;
      tmp_q       <= tmp_d;
      out_valid_q <= out_valid_d;
      tmp_valid_q <= tmp_valid_d;
      ready_q     <= !tmp_valid_d;
    end
  end

  assign s_ready_o = ready_q;
  assign m_data_o  = out_q.data;
  assign m_last_o  = out_q.last;
  assign m_user_o  = out_q.user;
  assign m_valid_o = out_valid_q;

endmodule

// File: rtl/eth_axis_hdr_rx.sv
// Ethernet header parser: captures the 14-byte MAC header into fields and forwards the payload.
module eth_axis_hdr_rx
  import eth_axis_hdr_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  eth_axis_hdr_rx_if.slave bus,
  output logic             busy,
  output logic             error_header_early_termination
);

  if (DATA_WIDTH != 8) begin : g_width_check
    $error("eth_axis_hdr_rx: only DATA_WIDTH = 8 is supported");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [HDR_W-9:0] shift_q, shift_d;
  eth_hdr_t         hdr_q, hdr_d;
  logic             hdr_valid_q, hdr_valid_d;
  logic             hdr_rdy_q;
  logic             err_q, err_d;
  logic             s_tready, s_accept, skid_valid, skid_ready;

  // Header side takes a byte only once the previous header has been consumed.
  always_comb begin
    s_tready = hdr_rdy_q;
    if (state_q == ST_PAYLOAD)   s_tready = skid_ready;
    else if (state_q == ST_DROP) s_tready = 1'b1;
  end

  assign s_accept = bus.s_axis_tvalid && s_tready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    hdr_d       = hdr_q;
    hdr_valid_d = hdr_valid_q && !bus.m_eth_hdr_ready;
    err_d       = 1'b0;
    skid_valid  = 1'b0;
    case (state_q)
      ST_IDLE, ST_HEADER: begin
        if (cnt_q > CNT_W'(ETH_HDR_LEN - 1)) begin
          state_d = ST_DROP;
        end else if (s_accept) begin
          shift_d = {shift_q[HDR_W-17:0], bus.s_axis_tdata};
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_HEADER;
          if (bus.s_axis_tlast) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else if (cnt_q == CNT_W'(ETH_HDR_LEN - 1)) begin
            hdr_d       = eth_hdr_t'({shift_q, bus.s_axis_tdata});
            hdr_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        skid_valid = bus.s_axis_tvalid;
        if (s_accept && bus.s_axis_tlast) state_d = ST_IDLE;
      end
      ST_DROP: begin
        if (s_accept && bus.s_axis_tlast) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      hdr_q       <= '0;
      hdr_valid_q <= 1'b0;
      hdr_rdy_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      hdr_q       <= hdr_d;
      hdr_valid_q <= hdr_valid_d;
      hdr_rdy_q   <= !hdr_valid_d;
      err_q       <= err_d;
    end
  end

  axis_skid_buf_8 u_skid (
    .clk       (clk),
    .rst       (rst),
    .s_data_i  (bus.s_axis_tdata),
    .s_last_i  (bus.s_axis_tlast),
    .s_user_i  (bus.s_axis_tuser && bus.s_axis_tlast),
    .s_valid_i (skid_valid),
    .s_ready_o (skid_ready),
    .m_data_o  (bus.m_eth_payload_axis_tdata),
    .m_last_o  (bus.m_eth_payload_axis_tlast),
    .m_user_o  (bus.m_eth_payload_axis_tuser),
    .m_valid_o (bus.m_eth_payload_axis_tvalid),
    .m_ready_i (bus.m_eth_payload_axis_tready)
  );

  assign bus.s_axis_tready   = s_tready;
  assign bus.m_eth_hdr_valid = hdr_valid_q;
  assign bus.m_eth_dest_mac  = hdr_q.dest;
  assign bus.m_eth_src_mac   = hdr_q.src;
  assign bus.m_eth_type      = hdr_q.etype;
  assign busy                = (state_q != ST_IDLE);
  assign error_header_early_termination = err_q;

endmodule

// File: tb/tb_eth_axis_hdr_rx.sv
// Bench for eth_axis_hdr_rx: frame-level reference model with header/payload scoreboards.
module tb_eth_axis_hdr_rx;
  import eth_axis_hdr_rx_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, err;

  eth_axis_hdr_rx_if bus();

  eth_axis_hdr_rx #(.DATA_WIDTH(8)) dut (
    .clk                            (clk),
    .rst                            (rst),
    .bus                            (bus),
    .busy                           (busy),
    .error_header_early_termination (err)
  );

  always #5 clk = ~clk;

  localparam logic [111:0] FIXED_HDR = 112'h020000000001_5A5152535455_0800;

  int n_checks = 0;
  int n_fail   = 0;
  logic [111:0] exp_hdr_q[$];
  logic [9:0]   exp_pay_q[$];
  logic [7:0]   frame_q[$];
  int hdrs_seen = 0, pays_seen = 0, errs_seen = 0, exp_errs = 0;
  int pay_pct = 100, hdr_pct = 100;
  bit hdr_hold = 1'b0, drv_payload = 1'b0;
  int stall_acc = 0, stall_max = 0;
  logic [111:0] last_hdr = '0, prev_fields = '0, cur_fields;
  logic prev_hv = 1'b0, prev_hr = 1'b0, prev_err = 1'b0;

  task automatic chk(input string name, input logic [111:0] act, input logic [111:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string why);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s", name, why);
  endtask

  // Reference model: bytes 0..13 are the header (byte i at bits 111-8i), the rest is payload.
  task automatic model_frame(input bit user);
    int n;
    logic [111:0] h;
    logic lst;
    n = frame_q.size();
    h = '0;
    if (n <= ETH_HDR_LEN) begin
      exp_errs++;
    end else begin
      for (int i = 0; i < ETH_HDR_LEN; i++) h[111 - 8*i -: 8] = frame_q[i];
      exp_hdr_q.push_back(h);
      for (int i = ETH_HDR_LEN; i < n; i++) begin
        lst = (i == n - 1);
        exp_pay_q.push_back({lst & user, lst, frame_q[i]});
      end
    end
  endtask

  task automatic build_frame(input int len, input bit fixed);
    logic [111:0] fh;
    fh = FIXED_HDR;
    frame_q.delete();
    for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom));
    if (fixed) begin
      for (int i = 0; i < len; i++)
        frame_q[i] = (i < ETH_HDR_LEN) ? fh[111 - 8*i -: 8] : 8'(i - ETH_HDR_LEN);
    end
  endtask

  task automatic do_reset();
    bus.s_axis_tvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_hdr_valid", bus.m_eth_hdr_valid, 0);
    chk("rst_pay_valid", bus.m_eth_payload_axis_tvalid, 0);
    chk("rst_s_tready", bus.s_axis_tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_fields", {bus.m_eth_dest_mac, bus.m_eth_src_mac, bus.m_eth_type}, 0);
    exp_hdr_q.delete();
    exp_pay_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send_frame(input bit user, input int gap_pct, input int rst_at);
    int n, w;
    n = frame_q.size();
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        do_reset();
        return;
      end
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        bus.s_axis_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      bus.s_axis_tdata  = frame_q[i];
      bus.s_axis_tlast  = (i == n - 1);
      bus.s_axis_tuser  = (i == n - 1) ? user : 1'($urandom);
      bus.s_axis_tvalid = 1'b1;
      drv_payload       = (i >= ETH_HDR_LEN);
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!bus.s_axis_tready && w < 3000);
      if (!bus.s_axis_tready) begin
        fail("s_tready_timeout", "input byte never accepted");
        bus.s_axis_tvalid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tuser  = 1'b0;
    drv_payload       = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_hdr_q.size() != 0 || exp_pay_q.size() != 0) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    chk("drain_hdr_left", exp_hdr_q.size(), 0);
    chk("drain_pay_left", exp_pay_q.size(), 0);
    chk("busy_idle", busy, 0);
    chk("err_count", errs_seen, exp_errs);
    @(posedge clk); #1;
  endtask

  // Output monitor and scoreboards, sampled mid-cycle.
  always @(negedge clk) begin
    cur_fields = {bus.m_eth_dest_mac, bus.m_eth_src_mac, bus.m_eth_type};
    if (rst) begin
      prev_hv   = 1'b0;
      prev_err  = 1'b0;
      stall_acc = 0;
    end else begin
      if (prev_hv && !prev_hr) begin
        chk("hdr_valid_held", bus.m_eth_hdr_valid, 1);
        chk("hdr_fields_stable", cur_fields, prev_fields);
      end
      if (bus.m_eth_hdr_valid && bus.m_eth_hdr_ready) begin
        hdrs_seen++;
        last_hdr = cur_fields;
        if (exp_hdr_q.size() == 0) fail("unexpected_hdr", "header output with none expected");
        else chk("hdr_fields", cur_fields, exp_hdr_q.pop_front());
      end
      if (bus.m_eth_payload_axis_tvalid && bus.m_eth_payload_axis_tready) begin
        pays_seen++;
        if (exp_pay_q.size() == 0) fail("unexpected_payload", "payload beat with none expected");
        else chk("payload_beat", {bus.m_eth_payload_axis_tuser, bus.m_eth_payload_axis_tlast,
                                  bus.m_eth_payload_axis_tdata}, exp_pay_q.pop_front());
      end
      if (err) begin
        errs_seen++;
        chk("err_pulse_width", prev_err, 0);
      end
      if (bus.m_eth_payload_axis_tvalid && !bus.m_eth_payload_axis_tready) begin
        if (bus.s_axis_tvalid && bus.s_axis_tready && drv_payload) begin
          stall_acc++;
          if (stall_acc > stall_max) stall_max = stall_acc;
        end
      end else begin
        stall_acc = 0;
      end
      prev_hv     = bus.m_eth_hdr_valid;
      prev_hr     = bus.m_eth_hdr_ready;
      prev_fields = cur_fields;
      prev_err    = err;
    end
  end

  initial begin
    bus.m_eth_hdr_ready           = 1'b0;
    bus.m_eth_payload_axis_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.m_eth_payload_axis_tready = (int'($urandom_range(99)) < pay_pct);
      bus.m_eth_hdr_ready           = !hdr_hold && (int'($urandom_range(99)) < hdr_pct);
    end
  end

  typedef struct {
    int len;
    bit user;
    bit fixed;
    int pay_pct;
    int hdr_pct;
    int exp_hdrs;
    int exp_errs;
    int exp_pay;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int h0, p0, e0, seen_rdy, len;
    bit user;

    vecs[0] = '{60,  1'b0, 1'b1, 100, 100, 1, 0, 46};
    vecs[1] = '{60,  1'b1, 1'b1, 100, 100, 1, 0, 46};
    vecs[2] = '{10,  1'b0, 1'b0, 100, 100, 0, 1, 0};
    vecs[3] = '{15,  1'b0, 1'b0, 100, 100, 1, 0, 1};
    vecs[4] = '{14,  1'b0, 1'b0, 100, 100, 0, 1, 0};
    vecs[5] = '{1,   1'b1, 1'b0, 100, 100, 0, 1, 0};
    vecs[6] = '{200, 1'b0, 1'b0, 50,  100, 1, 0, 186};
    vecs[7] = '{13,  1'b1, 1'b0, 100, 100, 0, 1, 0};
    vecs[8] = '{16,  1'b1, 1'b0, 30,  30,  1, 0, 2};

    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tuser  = 1'b0;
    do_reset();
    @(posedge clk); #1;

    for (int v = 0; v < 9; v++) begin
      h0 = hdrs_seen; p0 = pays_seen; e0 = errs_seen;
      pay_pct = vecs[v].pay_pct;
      hdr_pct = vecs[v].hdr_pct;
      stall_max = 0;
      build_frame(vecs[v].len, vecs[v].fixed);
      model_frame(vecs[v].user);
      send_frame(vecs[v].user, 0, -1);
      drain();
      chk("vec_hdr_count", hdrs_seen - h0, vecs[v].exp_hdrs);
      chk("vec_pay_count", pays_seen - p0, vecs[v].exp_pay);
      chk("vec_err_count", errs_seen - e0, vecs[v].exp_errs);
      chk("vec_stall_bound", stall_max <= 2, 1);
      if (vecs[v].fixed) chk("vec_fixed_hdr", last_hdr, FIXED_HDR);
    end

    // Back-to-back frames while the first header is left pending.
    pay_pct = 100; hdr_pct = 100; hdr_hold = 1'b1;
    build_frame(64, 1'b0);
    model_frame(1'b0);
    send_frame(1'b0, 0, -1);
    build_frame(64, 1'b0);
    model_frame(1'b0);
    bus.s_axis_tdata  = frame_q[0];
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tuser  = 1'b0;
    bus.s_axis_tvalid = 1'b1;
    seen_rdy = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.s_axis_tready) seen_rdy++;
    end
    chk("b2b_tready_low", seen_rdy, 0);
    chk("b2b_hdr_pending", bus.m_eth_hdr_valid, 1);
    chk("b2b_payload_independent", exp_pay_q.size(), 50);
    @(posedge clk); #1;
    hdr_hold = 1'b0;
    send_frame(1'b0, 0, -1);
    drain();

    // Reset at payload byte 20, then a fresh frame.
    build_frame(60, 1'b0);
    model_frame(1'b0);
    send_frame(1'b0, 0, ETH_HDR_LEN + 20);
    drain();
    build_frame(60, 1'b1);
    model_frame(1'b0);
    send_frame(1'b0, 0, -1);
    drain();
    chk("post_rst_hdr", last_hdr, FIXED_HDR);

    // Randomized frames, lengths, gaps and backpressure.
    for (int r = 0; r < 8; r++) begin
      len  = int'($urandom_range(90, 1));
      user = 1'($urandom);
      pay_pct = int'($urandom_range(100, 40));
      hdr_pct = int'($urandom_range(100, 40));
      stall_max = 0;
      build_frame(len, 1'b0);
      model_frame(user);
      send_frame(user, 20, -1);
      drain();
      chk("rand_stall_bound", stall_max <= 2, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
